// File: rtl/int_div_seq.sv
// int_div_seq: sequential radix-2 restoring integer divider with valid/ready handshake and tag pass-through.
// Define DIV_SIGNED_EN to compile in two's-complement signed division; otherwise all ops are unsigned.
module int_div_seq #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             CCLK,
  input  logic             ExIReset_L,
  input  logic             DivAbort,
  input  logic             DivInValid,
  output logic             DivInReady,
  input  logic             DivSigned,
  input  logic [WIDTH-1:0] DivDividend,
  input  logic [WIDTH-1:0] DivDivisor,
  input  logic [TAG_W-1:0] DivTagIn,
  output logic             DivOutValid,
  input  logic             DivOutReady,
  output logic [WIDTH-1:0] DivQuotient,
  output logic [WIDTH-1:0] DivRemainder,
  output logic [TAG_W-1:0] DivTagOut,
  output logic             DivError,
  output logic             DivBusy
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, PRE, ITER, POST, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] quo_acc_q, quo_acc_d;
  logic [WIDTH-1:0] rem_acc_q, rem_acc_d;
  logic             err_acc_q, err_acc_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_quo_q, out_quo_d;
  logic [WIDTH-1:0] out_rem_q, out_rem_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             out_err_q, out_err_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic sgn_q, sgn_d;
  logic qneg_q, qneg_d;
  logic rneg_q, rneg_d;
  logic a_neg, b_neg, ovf;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ((~v) + WIDTH'(1)) : v;
  endfunction

  // Only meaningful in PRE, while op_a/op_b still hold the raw operands.
  assign a_neg = sgn_q & op_a_q[WIDTH-1];
  assign b_neg = sgn_q & op_b_q[WIDTH-1];
  assign ovf   = sgn_q && (op_a_q == MOST_NEG) && (op_b_q == '1);
`else
  logic unused_signed;
  assign unused_signed = DivSigned;
`endif

  // One restoring step: shift the next dividend bit into the partial remainder, subtract if it fits.
  assign shifted = {rem_acc_q, quo_acc_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, op_b_q};
  assign fits    = ~diff[WIDTH];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    quo_acc_d   = quo_acc_q;
    rem_acc_d   = rem_acc_q;
    err_acc_d   = err_acc_q;
    tag_d       = tag_q;
    out_valid_d = out_valid_q;
    out_quo_d   = out_quo_q;
    out_rem_d   = out_rem_q;
    out_tag_d   = out_tag_q;
    out_err_d   = out_err_q;
`ifdef DIV_SIGNED_EN
    sgn_d       = sgn_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (DivInValid) begin
          op_a_d  = DivDividend;
          op_b_d  = DivDivisor;
          tag_d   = DivTagIn;
`ifdef DIV_SIGNED_EN
          sgn_d   = DivSigned;
`endif
          state_d = PRE;
        end
      end

      PRE: begin
        cnt_d     = '0;
        rem_acc_d = '0;
        err_acc_d = 1'b0;
`ifdef DIV_SIGNED_EN
        quo_acc_d = cond_neg(op_a_q, a_neg);
        op_b_d    = cond_neg(op_b_q, b_neg);
        qneg_d    = a_neg ^ b_neg;
        rneg_d    = a_neg;
`else
        quo_acc_d = op_a_q;
`endif
        state_d   = ITER;
        if (op_b_q == '0) begin
          quo_acc_d = '1;
          rem_acc_d = op_a_q;
          err_acc_d = 1'b1;
          state_d   = DONE;
        end
`ifdef DIV_SIGNED_EN
        else if (ovf) begin
          quo_acc_d = MOST_NEG;
          rem_acc_d = '0;
          err_acc_d = 1'b1;
          state_d   = DONE;
        end
`endif
      end

      ITER: begin
        rem_acc_d = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_acc_d = {quo_acc_q[WIDTH-2:0], fits};
        cnt_d     = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = POST;
        end
      end

      POST: begin
`ifdef DIV_SIGNED_EN
        quo_acc_d = cond_neg(quo_acc_q, qneg_q);
        rem_acc_d = cond_neg(rem_acc_q, rneg_q);
`endif
        state_d = DONE;
      end

      DONE: begin
        // First DONE cycle registers the result; afterwards hold until the consumer takes it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          out_quo_d   = quo_acc_q;
          out_rem_d   = rem_acc_q;
          out_tag_d   = tag_q;
          out_err_d   = err_acc_q;
        end else if (DivOutReady) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (DivAbort) begin
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge CCLK or negedge ExIReset_L) begin
    if (!ExIReset_L) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      quo_acc_q   <= '0;
      rem_acc_q   <= '0;
      err_acc_q   <= 1'b0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_quo_q   <= '0;
      out_rem_q   <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
      sgn_q       <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      quo_acc_q   <= quo_acc_d;
      rem_acc_q   <= rem_acc_d;
      err_acc_q   <= err_acc_d;
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_quo_q   <= out_quo_d;
      out_rem_q   <= out_rem_d;
      out_tag_q   <= out_tag_d;
      out_err_q   <= out_err_d;
`ifdef DIV_SIGNED_EN
      sgn_q       <= sgn_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
`endif
    end
  end

  assign DivInReady   = (state_q == IDLE);
  assign DivBusy      = (state_q != IDLE);
  assign DivOutValid  = out_valid_q;
  assign DivQuotient  = out_quo_q;
  assign DivRemainder = out_rem_q;
  assign DivTagOut    = out_tag_q;
  assign DivError     = out_err_q;

endmodule

// File: tb/tb_int_div_seq.sv
// Scoreboard testbench for int_div_seq: random and directed divisions checked against a plain-arithmetic model.
module tb_int_div_seq;
  localparam int W       = 32;
  localparam int TW      = 5;
  localparam int LAT_MAX = W + 20;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef struct packed {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  logic          CCLK = 1'b0;
  logic          ExIReset_L = 1'b0;
  logic          DivAbort = 1'b0;
  logic          DivInValid = 1'b0;
  logic          DivInReady;
  logic          DivSigned = 1'b0;
  logic [W-1:0]  DivDividend = '0;
  logic [W-1:0]  DivDivisor = '0;
  logic [TW-1:0] DivTagIn = '0;
  logic          DivOutValid;
  logic          DivOutReady = 1'b0;
  logic [W-1:0]  DivQuotient;
  logic [W-1:0]  DivRemainder;
  logic [TW-1:0] DivTagOut;
  logic          DivError;
  logic          DivBusy;

  int   checks = 0;
  int   passes = 0;
  exp_t exp_q[$];

  int_div_seq #(.WIDTH(W), .TAG_W(TW)) dut (
    .CCLK(CCLK), .ExIReset_L(ExIReset_L), .DivAbort(DivAbort),
    .DivInValid(DivInValid), .DivInReady(DivInReady), .DivSigned(DivSigned),
    .DivDividend(DivDividend), .DivDivisor(DivDivisor), .DivTagIn(DivTagIn),
    .DivOutValid(DivOutValid), .DivOutReady(DivOutReady),
    .DivQuotient(DivQuotient), .DivRemainder(DivRemainder),
    .DivTagOut(DivTagOut), .DivError(DivError), .DivBusy(DivBusy)
  );

  always #5 CCLK = ~CCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required run to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Truncating division from plain SV arithmetic; error cases per the block's defined results.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic s, input logic [TW-1:0] t);
    exp_t e;
`ifdef DIV_SIGNED_EN
    logic signed [W-1:0] sa, sd;
    sa = a;
    sd = b;
`else
    logic unused_s;
    unused_s = s;
`endif
    e.tag = t;
    e.err = 1'b0;
    if (b == '0) begin
      e.q = '1; e.r = a; e.err = 1'b1;
    end
`ifdef DIV_SIGNED_EN
    else if (s && a == MIN_NEG && b == '1) begin
      e.q = MIN_NEG; e.r = '0; e.err = 1'b1;
    end else if (s) begin
      e.q = sa / sd; e.r = sa % sd;
    end
`endif
    else begin
      e.q = a / b; e.r = a % b;
    end
    return e;
  endfunction

  always @(negedge CCLK) begin
    if (ExIReset_L && DivOutValid && DivOutReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_result: got valid q=0x%0h tag=0x%0h, required no result", DivQuotient, DivTagOut);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("mon_quotient", 64'(DivQuotient), 64'(e.q));
        chk("mon_remainder", 64'(DivRemainder), 64'(e.r));
        chk("mon_tag", 64'(DivTagOut), 64'(e.tag));
        chk("mon_error", 64'(DivError), 64'(e.err));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!DivInReady && n < 100) begin
      @(posedge CCLK); #1; n++;
    end
    chk("in_ready", 64'(DivInReady), 64'd1);
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input logic [TW-1:0] t, input logic rdy);
    @(negedge CCLK);
    DivDividend = a; DivDivisor = b; DivSigned = s; DivTagIn = t;
    DivInValid = 1'b1; DivOutReady = rdy;
    @(posedge CCLK);
    #1 DivInValid = 1'b0;
    DivDividend = $urandom; DivDivisor = $urandom; DivTagIn = ~t;
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [TW-1:0] t, input int stall);
    exp_t e;
    int   n;
    wait_ready();
    e = model(a, b, s, t);
    exp_q.push_back(e);
    accept(a, b, s, t, stall == 0);
    n = 0;
    while (!DivOutValid && n < LAT_MAX) begin
      @(posedge CCLK); n++; #1;
    end
    chk("latency", 64'(n), e.err ? 64'd2 : 64'(W + 3));
    for (int k = 0; k < stall; k++) begin
      chk("hold_quotient", 64'(DivQuotient), 64'(e.q));
      chk("hold_remainder", 64'(DivRemainder), 64'(e.r));
      chk("hold_tag", 64'(DivTagOut), 64'(e.tag));
      chk("hold_valid", 64'(DivOutValid), 64'd1);
      chk("hold_in_ready", 64'(DivInReady), 64'd0);
      @(posedge CCLK); #1;
    end
    DivOutReady = 1'b1;
    @(posedge CCLK); #1;
    chk("ret_in_ready", 64'(DivInReady), 64'd1);
    chk("ret_valid_low", 64'(DivOutValid), 64'd0);
  endtask

  task automatic count_no_valid(input string name, input int cycles);
    int nvalid = 0;
    repeat (cycles) begin
      @(posedge CCLK); #1;
      if (DivOutValid) nvalid++;
    end
    chk(name, 64'(nvalid), 64'd0);
  endtask

  task automatic abort_iter_test();
    wait_ready();
    accept(32'd1000, 32'd3, 1'b0, 5'h1A, 1'b1);
    repeat (5) @(posedge CCLK);
    #1 chk("abort_iter_busy_before", 64'(DivBusy), 64'd1);
    DivAbort = 1'b1;
    @(posedge CCLK);
    #1 DivAbort = 1'b0;
    chk("abort_iter_busy", 64'(DivBusy), 64'd0);
    chk("abort_iter_in_ready", 64'(DivInReady), 64'd1);
    count_no_valid("abort_iter_no_result", W + 8);
  endtask

  task automatic abort_done_test();
    int n = 0;
    wait_ready();
    accept(32'd50, 32'd5, 1'b0, 5'h1B, 1'b0);
    while (!DivOutValid && n < LAT_MAX) begin
      @(posedge CCLK); n++; #1;
    end
    chk("abort_done_valid", 64'(DivOutValid), 64'd1);
    DivAbort = 1'b1;
    @(posedge CCLK);
    #1 DivAbort = 1'b0;
    chk("abort_done_valid_low", 64'(DivOutValid), 64'd0);
    chk("abort_done_busy", 64'(DivBusy), 64'd0);
    DivOutReady = 1'b1;
    count_no_valid("abort_done_no_result", 8);
  endtask

  task automatic reset_pulse_test();
    wait_ready();
    accept(32'd77, 32'd5, 1'b0, 5'h1C, 1'b1);
    repeat (10) @(posedge CCLK);
    #2 ExIReset_L = 1'b0;
    #1;
    chk("rstp_busy", 64'(DivBusy), 64'd0);
    chk("rstp_valid", 64'(DivOutValid), 64'd0);
    chk("rstp_quotient", 64'(DivQuotient), 64'd0);
    chk("rstp_remainder", 64'(DivRemainder), 64'd0);
    chk("rstp_tag", 64'(DivTagOut), 64'd0);
    @(negedge CCLK);
    ExIReset_L = 1'b1;
    count_no_valid("rstp_no_result", W + 8);
    chk("rstp_in_ready", 64'(DivInReady), 64'd1);
  endtask

  initial begin
    DivOutReady = 1'b1;
    repeat (3) @(posedge CCLK);
    #1;
    chk("rst_valid", 64'(DivOutValid), 64'd0);
    chk("rst_busy", 64'(DivBusy), 64'd0);
    chk("rst_error", 64'(DivError), 64'd0);
    chk("rst_quotient", 64'(DivQuotient), 64'd0);
    chk("rst_remainder", 64'(DivRemainder), 64'd0);
    chk("rst_tag", 64'(DivTagOut), 64'd0);
    @(negedge CCLK);
    ExIReset_L = 1'b1;
    @(posedge CCLK);
    #1 chk("rst_in_ready", 64'(DivInReady), 64'd1);

    do_op(32'd100, 32'd7, 1'b0, 5'h03, 0);
    do_op(32'd5, 32'd0, 1'b0, 5'h04, 0);
    do_op(32'd1000, 32'd10, 1'b0, 5'h11, 10);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 5'h05, 0);
    do_op(MIN_NEG, 32'hFFFF_FFFF, 1'b1, 5'h06, 0);
    do_op(MIN_NEG, 32'd1, 1'b1, 5'h07, 1);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 5'h08, 0);
    do_op(32'd0, 32'hFFFF_FFFF, 1'b0, 5'h09, 2);
    do_op(32'd7, 32'hFFFF_FFF9, 1'b1, 5'h0A, 0);

    abort_iter_test();
    do_op(32'd9, 32'd3, 1'b0, 5'h0B, 0);
    abort_done_test();
    reset_pulse_test();
    do_op(32'd9, 32'd3, 1'b0, 5'h0C, 0);

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, b;
      logic         s;
      int           sel;
      sel = $urandom_range(0, 15);
      a = $urandom;
      b = $urandom;
      s = 1'($urandom_range(0, 1));
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = MIN_NEG; b = '1; s = 1'b1; end
      else if (sel < 6) b = $urandom_range(1, 15);
      else if (sel < 9) b = b >> $urandom_range(0, W - 1);
      if (sel == 9) a = MIN_NEG;
      do_op(a, b, s, TW'(i), $urandom_range(0, 3));
    end

    repeat (3) @(posedge CCLK);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/int_div_seq.md
INT_DIV_SEQ -- requirements
Module: int_div_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width; legal values 8..64.
REQ-002 SHALL provide parameter TAG_W, default 5, width of the pass-through destination tag.
REQ-003 SHALL have port CCLK, input, 1 bit, the single clock; all flops on its rising edge.
REQ-004 SHALL have port ExIReset_L, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port DivAbort, input, 1 bit, flushes any in-flight op.
REQ-006 SHALL have port DivInValid, input, 1 bit, request valid.
REQ-007 SHALL have port DivInReady, output, 1 bit, block can accept a request.
REQ-008 SHALL have port DivSigned, input, 1 bit, signed (two's complement) op.
REQ-009 SHALL have ports DivDividend and DivDivisor, inputs, WIDTH bits each, operands.
REQ-010 SHALL have port DivTagIn, input, TAG_W bits, destination tag captured with the request.
REQ-011 SHALL have port DivOutValid, output, 1 bit, result valid.
REQ-012 SHALL have port DivOutReady, input, 1 bit, consumer accepts the result.
REQ-013 SHALL have ports DivQuotient and DivRemainder, outputs, WIDTH bits each, results.
REQ-014 SHALL have ports DivTagOut (TAG_W bits), DivError (1 bit) and DivBusy (1 bit), all outputs.

Function
REQ-015 SHALL implement FSM states IDLE, PRE, ITER, POST and DONE.
REQ-016 SHALL drive DivInReady=1 only in IDLE; accept occurs on a rising edge with DivInValid&DivInReady, latching operands, DivSigned and DivTagIn; transition IDLE->PRE.
REQ-017 In PRE, SHALL take magnitudes of signed operands, record quotient sign (XOR of operand signs) and remainder sign (dividend sign), and detect divide-by-zero and signed overflow (dividend=most-negative, divisor=-1).
REQ-018 On error detect in PRE, SHALL go PRE->DONE with DivError=1: divide-by-zero gives quotient all-ones and remainder = original dividend; overflow gives quotient = most-negative value and remainder 0.
REQ-019 Otherwise, SHALL go PRE->ITER and perform radix-2 restoring division, one quotient bit per cycle MSB first, for exactly WIDTH cycles via an internal counter, then ITER->POST.
REQ-020 In POST, SHALL negate quotient/remainder per recorded signs (remainder sign follows dividend, truncating division), then POST->DONE.
REQ-021 Latency: DivOutValid SHALL rise after edge WIDTH+3 counted from the accept edge (edge 0) for normal ops, and after edge 2 for error ops.
REQ-022 In DONE, SHALL hold DivOutValid=1 and quotient, remainder, tag and error stable until DivOutReady=1; on that edge SHALL go DONE->IDLE; a new request is accepted no earlier than the following edge.
REQ-023 DivBusy SHALL be 1 in every state other than IDLE.
REQ-024 DivAbort=1 SHALL force IDLE on the next edge from any state, including DONE, with priority over accept and DivOutReady; no DivOutValid results for the aborted op.
REQ-025 DivQuotient, DivRemainder, DivTagOut and DivError SHALL be registered outputs; when DivOutValid=0 their values are don't-care.

Reset
REQ-026 Assertion of ExIReset_L=0 SHALL immediately force IDLE, zero the counter, DivOutValid=0, DivError=0, DivBusy=0, and zero the quotient, remainder and tag registers; DivInReady=1 is seen after deassertion.
REQ-027 Reset mid-operation SHALL discard the op with no result produced.

Configuration
REQ-028 Macro DIV_SIGNED_EN defined: signed handling per REQ-017/018/020 compiled in.
REQ-029 Macro DIV_SIGNED_EN undefined: DivSigned ignored; all ops unsigned; overflow detection and sign-fix logic absent; POST is a single pass-through cycle, so latency is unchanged.

Verification
REQ-030 WIDTH=32, unsigned 100/7 -> quotient 14, remainder 2, DivError=0, DivOutValid after edge 35.
REQ-031 Signed -7/2 (DIV_SIGNED_EN) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF, DivError=0.
REQ-032 5/0 -> quotient 0xFFFFFFFF, remainder 5, DivError=1 after edge 2; signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0, DivError=1.
REQ-033 Result 1000/10 with DivOutReady low for 10 cycles -> outputs (quotient 100, remainder 0) and tag stable, DivInReady=0 throughout; DivInReady=1 one edge after DivOutReady.
REQ-034 DivAbort at ITER cycle 5, and separately ExIReset_L pulsed mid-ITER -> IDLE, DivBusy=0, no DivOutValid; the next op 9/3 -> quotient 3, remainder 0.
